// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes, tag and flags.
// Define ALU_MUL_EN to build the iterative shift-add multiply (sel=101).
module alu_pipe #(
  parameter int WIDTH = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic [ID_W-1:0]  in_id,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [ID_W-1:0]  out_id,
  output logic             err,
  output logic             busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b110;

  logic             w_accept;
  logic             w_idle;
  logic             w_is_mul;
  logic             w_ld_alu;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_err;
  logic [3:0]       w_flags;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_res;
  logic             w_mul_c;
  logic [ID_W-1:0]  w_mul_id;
  logic [3:0]       w_mul_flags;

  assign w_sum = {1'b0, a} + {1'b0, b};
  assign w_dif = {1'b0, a} - {1'b0, b};

  // Single-cycle operations; anything not decoded here is reserved.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    unique case (1'b1)
      (sel == OP_ADD): begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      (sel == OP_SUB): begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                (w_dif[WIDTH-1] != a[WIDTH-1]);
      end
      (sel == OP_AND): w_res = a & b;
      (sel == OP_OR):  w_res = a | b;
      (sel == OP_NOT): w_res = ~a;
      (sel == OP_XOR): w_res = a ^ b;
      default:         w_err = 1'b1;
    endcase
  end

  assign w_flags = {w_v, w_c, w_res[WIDTH-1], ~|w_res};

`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [ID_W-1:0]    r_mid;
  logic [2*WIDTH-1:0] w_prod_nxt;

  assign w_idle     = (r_state == S_IDLE);
  assign w_is_mul   = (sel == OP_MUL);
  assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == CNT_LAST);
  assign w_mul_res  = w_prod_nxt[WIDTH-1:0];
  assign w_mul_c    = |w_prod_nxt[2*WIDTH-1:WIDTH];
  assign w_mul_id   = r_mid;
  assign busy       = (r_state == S_MUL);

  // Shift-add multiply: one bit of B per cycle, LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_mid    <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept && w_is_mul) begin
        r_state  <= S_MUL;
        r_cnt    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, a};
        r_mplier <= b;
        r_prod   <= '0;
        r_mid    <= in_id;
      end
    end else begin
      r_prod   <= w_prod_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_mul_done) r_state <= S_IDLE;
    end
  end
`else
  assign w_idle     = 1'b1;
  assign w_is_mul   = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_res  = '0;
  assign w_mul_c    = 1'b0;
  assign w_mul_id   = '0;
  assign busy       = 1'b0;
`endif

  assign w_mul_flags = {1'b0, w_mul_c,
                        w_mul_res[WIDTH-1], ~|w_mul_res};

  assign in_ready = w_idle && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_ld_alu = w_accept && !w_is_mul;

  // One-entry output register; a same-edge load wins over the drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      out_id    <= '0;
      err       <= 1'b0;
    end else if (w_ld_alu) begin
      out_valid <= 1'b1;
      result    <= w_res;
      flags     <= w_flags;
      out_id    <= in_id;
      err       <= w_err;
    end else if (w_mul_done) begin
      out_valid <= 1'b1;
      result    <= w_mul_res;
      flags     <= w_mul_flags;
      out_id    <= w_mul_id;
      err       <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random stimulus for alu_pipe.
// Outputs are compared every cycle against a transaction-level model.
module tb_alu_pipe;

  localparam int W  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2:0]    sel = '0;
  logic [IW-1:0] in_id = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic [3:0]    flags;
  logic [IW-1:0] out_id;
  logic          err;
  logic          busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .out_id(out_id),
    .err(err), .busy(busy)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Returns {err, ovf, carry, neg, zero, result} from plain arithmetic.
  function automatic logic [W+4:0] ref_alu(int x, int y, int s);
    int m = 1 << W;
    int h = 1 << (W - 1);
    int t = 0;
    int r = 0;
    int sx, sy, ss;
    bit c = 1'b0;
    bit v = 1'b0;
    bit e = 1'b0;
    sx = (x >= h) ? x - m : x;
    sy = (y >= h) ? y - m : y;
    case (s)
      0: begin
        t = x + y; r = t % m; c = (t >= m);
        ss = sx + sy; v = (ss >= h) || (ss < -h);
      end
      1: begin
        t = x - y; r = (t + m) % m; c = (x < y);
        ss = sx - sy; v = (ss >= h) || (ss < -h);
      end
      2: r = x & y;
      3: r = x | y;
      4: r = (m - 1) - x;
      5: begin
`ifdef ALU_MUL_EN
        t = x * y; r = t % m; c = ((t / m) != 0);
`else
        e = 1'b1;
`endif
      end
      6: r = x ^ y;
      default: e = 1'b1;
    endcase
    return {e, v, c, (r >= h), (r == 0), r[W-1:0]};
  endfunction

  // Model: output slot plus a countdown for an in-flight multiply.
  int            m_left = 0;
  int            n_left;
  logic          m_ov = 1'b0, n_ov;
  logic [W-1:0]  m_res = '0, n_res, m_pres = '0, n_pres;
  logic [3:0]    m_fl = '0, n_fl, m_pfl = '0, n_pfl;
  logic [IW-1:0] m_id = '0, n_id, m_pid = '0, n_pid;
  logic          m_err = 1'b0, n_err;
  logic          m_rdy, m_acc;
  logic          m_last_acc = 1'b0;
  logic [W+4:0]  m_r;

  // Next model state from the current transaction and handshakes.
  always_comb begin
    m_rdy  = (m_left == 0) && (!m_ov || out_ready);
    m_acc  = in_valid && m_rdy;
    m_r    = ref_alu(int'(a), int'(b), int'(sel));
    n_left = m_left;
    n_ov   = m_ov;
    n_res  = m_res;
    n_fl   = m_fl;
    n_id   = m_id;
    n_err  = m_err;
    n_pres = m_pres;
    n_pfl  = m_pfl;
    n_pid  = m_pid;
    if (m_ov && out_ready) n_ov = 1'b0;
    if (m_left > 0) begin
      n_left = m_left - 1;
      if (m_left == 1) begin
        n_ov  = 1'b1;
        n_res = m_pres;
        n_fl  = m_pfl;
        n_id  = m_pid;
        n_err = 1'b0;
      end
    end
    if (m_acc) begin
`ifdef ALU_MUL_EN
      if (sel == 3'd5) begin
        n_left = W;
        n_pres = m_r[W-1:0];
        n_pfl  = m_r[W+3:W];
        n_pid  = in_id;
      end else
`endif
      begin
        n_ov  = 1'b1;
        n_res = m_r[W-1:0];
        n_fl  = m_r[W+3:W];
        n_id  = in_id;
        n_err = m_r[W+4];
      end
    end
  end

  // Advance the model on each edge; reset clears everything at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_ov <= 1'b0;
      m_res <= '0;
      m_fl <= '0;
      m_id <= '0;
      m_err <= 1'b0;
      m_pres <= '0;
      m_pfl <= '0;
      m_pid <= '0;
      m_last_acc <= 1'b0;
    end else begin
      m_left <= n_left;
      m_ov <= n_ov;
      m_res <= n_res;
      m_fl <= n_fl;
      m_id <= n_id;
      m_err <= n_err;
      m_pres <= n_pres;
      m_pfl <= n_pfl;
      m_pid <= n_pid;
      m_last_acc <= m_acc;
    end
  end

  // Compare DUT outputs against the model every cycle.
  always @(negedge clk) begin
    chk("in_ready", in_ready, m_rdy);
    chk("out_valid", out_valid, m_ov);
    chk("busy", busy, m_left > 0);
    if (m_ov) begin
      chk("result", result, m_res);
      chk("flags", flags, m_fl);
      chk("out_id", out_id, m_id);
      chk("err", err, m_err);
    end
  end

  task automatic send(input int x, input int y,
                      input int s, input int id);
    int n = 0;
    in_valid = 1'b1;
    a = W'(x);
    b = W'(y);
    sel = 3'(s);
    in_id = IW'(id);
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_last_acc && n < 50);
    if (!m_last_acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm, input int r,
                            input int f, input int id,
                            input int e);
    @(negedge clk);
    chk({nm, ".valid"}, out_valid, 1);
    chk({nm, ".result"}, result, r);
    chk({nm, ".flags"}, flags, f);
    chk({nm, ".id"}, out_id, id);
    chk({nm, ".err"}, err, e);
  endtask

  task automatic expect_idle_zero(input string nm);
    chk({nm, ".valid"}, out_valid, 0);
    chk({nm, ".result"}, result, 0);
    chk({nm, ".flags"}, flags, 0);
    chk({nm, ".id"}, out_id, 0);
    chk({nm, ".err"}, err, 0);
    chk({nm, ".busy"}, busy, 0);
  endtask

  initial begin
    chk("ref_add", ref_alu(9, 8, 0), {1'b0, 4'b1100, 4'd1});
    chk("ref_sub", ref_alu(3, 5, 1), {1'b0, 4'b0110, 4'd14});
    chk("ref_subz", ref_alu(5, 5, 1), {1'b0, 4'b0001, 4'd0});
    chk("ref_xor", ref_alu(10, 12, 6), {1'b0, 4'b0000, 4'd6});
    chk("ref_rsv", ref_alu(7, 7, 7), {1'b1, 4'b0001, 4'd0});

    #7;
    expect_idle_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(9, 8, 0, 1);
    expect_out("add", 1, 4'b1100, 1, 0);
    send(3, 5, 1, 2);
    expect_out("sub", 14, 4'b0110, 2, 0);
    send(5, 5, 1, 3);
    expect_out("subz", 0, 4'b0001, 3, 0);

    send(6, 3, 5, 2);
`ifdef ALU_MUL_EN
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("mul.busy", busy, 1);
      chk("mul.in_ready", in_ready, 0);
      chk("mul.early_valid", out_valid, 0);
      @(posedge clk);
      #1;
    end
    expect_out("mul", 2, 4'b0100, 2, 0);
`else
    expect_out("mul_off", 0, 4'b0001, 2, 1);
`endif

    send(7, 7, 7, 1);
    expect_out("rsv", 0, 4'b0001, 1, 1);

    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(10, 12, 6, 2);
    in_valid = 1'b1;
    a = 4'd15;
    b = 4'd3;
    sel = 3'd2;
    in_id = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp.result", result, 6);
      chk("bp.valid", out_valid, 1);
      chk("bp.in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp.release_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expect_out("bp.and", 3, 4'b0000, 3, 0);

    @(posedge clk);
    #1;
    send(6, 3, 5, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    expect_idle_zero("midrst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst.no_valid", out_valid, 0);
    end

    @(posedge clk);
    #1;
    repeat (400) begin
      if (!in_valid || m_last_acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        a = W'($urandom);
        b = W'($urandom);
        sel = 3'($urandom_range(0, 7));
        in_id = IW'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
